// File: rtl/mem_dump_serializer_if.sv
// Memory read port and UART transmit handshake between the dump serializer and
// its neighbours. The master side is the serializer.
interface mem_dump_serializer_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [BYTE_WIDTH-1:0] tx_byte;
    logic                  tx_start;
    logic                  tx_done;

    modport master (
        output rd_addr,
        output tx_byte,
        output tx_start,
        input  rd_data,
        input  tx_done
    );

    modport slave (
        input  rd_addr,
        input  tx_byte,
        input  tx_start,
        output rd_data,
        output tx_done
    );
endinterface

// File: rtl/mem_dump_serializer.sv
// Walks a range of instruction-memory words and streams each word to the UART
// transmitter one byte at a time, least significant byte first.
module mem_dump_serializer #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic                  prog_rdy,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    mem_dump_serializer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned NBytes = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam int unsigned TmrW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IdxW-1:0]       LastIdx = IdxW'(NBytes - 1);
    localparam logic [TmrW-1:0]       TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0]   OneWord = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLatch,
        StSend,
        StWait,
        StNext,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [TmrW-1:0]       tmr_q, tmr_d, tmr_inc;
    logic                  error_q, error_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            tmr_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        word_d   = word_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        error_d  = error_q;
        tmr_inc  = tmr_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start && prog_rdy) begin
                    addr_d   = base_addr;
                    remain_d = word_count;
                    error_d  = 1'b0;
                    state_d  = (word_count == '0) ? StDone : StAddr;
                end
            end
            // Extra cycle lets a registered-output memory catch up with rd_addr.
            StAddr:  state_d = StLatch;
            StLatch: begin
                word_d  = bus.rd_data;
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // tx_done is checked first so it wins over a simultaneous expiry.
                if (bus.tx_done) begin
                    if (idx_q != LastIdx) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSend;
                    end else begin
                        state_d = StNext;
                    end
                end else begin
                    tmr_d = tmr_inc;
                    if (tmr_inc == TmrLast) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StNext: begin
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                state_d  = (remain_q == OneWord) ? StDone : StAddr;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.rd_addr  = addr_q;
    assign bus.tx_byte  = word_q[BYTE_WIDTH*idx_q +: BYTE_WIDTH];
    assign bus.tx_start = (state_q == StSend);
    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign done         = (state_q == StDone);
    assign error        = error_q;
endmodule

// File: tb/tb_mem_dump_serializer.sv
// Randomized bench for mem_dump_serializer: a memory and UART model drive the
// DUT, expected {address, byte} pairs are queued and checked on every tx_start.
module tb_mem_dump_serializer;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned TO = 16;
    localparam int NB = DW / BW;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start;
    logic          prog_rdy;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          error;

    mem_dump_serializer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

    mem_dump_serializer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .BYTE_WIDTH    (BW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .prog_rdy  (prog_rdy),
        .base_addr (base_addr),
        .word_count(word_count),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    bit uart_on = 1'b1;
    int uart_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: words base, base+1, ... modulo 256, each emitted LSB byte first.
    function automatic void push_dump(input logic [AW-1:0] base, input int cnt);
        logic [AW-1:0] a;
        logic [BW-1:0] bv;
        for (int w = 0; w < cnt; w++) begin
            a = base + AW'(w);
            for (int b = 0; b < NB; b++) begin
                bv = BW'((mem[a] >> (BW * b)) & 32'hFF);
                exp_q.push_back({a, bv});
            end
        end
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
    endtask

    // Scoreboard monitor
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (arst_n && bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got addr 0x%0h byte 0x%0h required none",
                             bus.rd_addr, bus.tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_addr_byte", {16'h0, bus.rd_addr, bus.tx_byte}, {16'h0, e});
                end
            end
        end
    end

    // UART model: answers each tx_start with a tx_done pulse after a delay
    initial begin : uart
        int  d;
        bit  ab;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            while (arst_n && bus.tx_start && uart_on) begin
                d  = (uart_delay != 0) ? uart_delay : int'($urandom_range(1, 6));
                ab = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (!arst_n) ab = 1'b1;
                end
                if (ab) break;
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    end

    task automatic run_dump(input logic [AW-1:0] base, input logic [AW:0] cnt, input bit inject);
        int k, ntx, first_k, last_k, done_k;
        bit busy_bad;
        push_dump(base, int'(cnt));
        @(negedge clk);
        prog_rdy   = 1'b1;
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        k = 0; ntx = 0; first_k = -1; last_k = -1; done_k = -1; busy_bad = 1'b0;
        while (k < 20000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("error_cleared", {31'h0, error}, 0);
            end
            if (inject && k == 2) begin
                start      = 1'b1;
                base_addr  = ~base;
                word_count = 5;
            end
            if (inject && k == 3) start = 1'b0;
            if (inject && k == 5) prog_rdy = 1'b0;
            if (bus.tx_start) begin
                ntx++;
                if (uart_delay != 0 && ntx > 1)
                    check("tx_gap", k - last_k,
                          ((ntx - 1) % NB == 0) ? uart_delay + 4 : uart_delay + 1);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (busy !== (cnt != 0)) busy_bad = 1'b1;
        end
        check("done_seen", {31'h0, done_k >= 0}, 1);
        if (cnt == 0) begin
            check("zero_done_lat", done_k, 1);
        end else begin
            check("first_tx_lat", first_k, 3);
            if (uart_delay != 0) check("done_lat", done_k - last_k, uart_delay + 2);
        end
        check("tx_count", ntx, int'(cnt) * NB);
        check("busy_level", {31'h0, busy_bad}, 0);
        check("busy_at_done", {31'h0, busy}, 0);
        check("no_error", {31'h0, error}, 0);
        check("sb_drained", exp_q.size(), 0);
        @(negedge clk);
        check("idle_after", {30'h0, busy, done}, 0);
        prog_rdy = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, ntx, first_k, done_k;
        logic [AW-1:0] b;
        arst_n = 1'b0; start = 1'b0; prog_rdy = 1'b0; base_addr = '0; word_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {12'h0, bus.rd_addr, bus.tx_byte, bus.tx_start, busy, done, error}, 0);
        arst_n = 1'b1;
        @(negedge clk);

        // Known word, fixed UART delay
        mem[0] = 32'h12345678;
        uart_delay = 5;
        run_dump(8'h00, 9'd1, 1'b0);

        // Address wrap
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        uart_delay = 0;
        run_dump(8'hFE, 9'd3, 1'b0);

        // Empty dump
        run_dump(8'h40, 9'd0, 1'b0);

        // Start without prog_rdy is ignored, then a start while busy is ignored
        prog_rdy = 1'b0;
        start = 1'b1; base_addr = 8'h22; word_count = 9'd2;
        @(negedge clk);
        start = 1'b0;
        ntx = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || done || bus.tx_start) ntx++;
        end
        check("no_prog_rdy_ignored", ntx, 0);
        fill_random();
        uart_delay = 2;
        run_dump(8'h10, 9'd2, 1'b1);

        // Timeout: transmitter never answers
        uart_on = 1'b0;
        fill_random();
        b = AW'($urandom());
        exp_q.push_back({b, mem[b][7:0]});
        @(negedge clk);
        prog_rdy = 1'b1; base_addr = b; word_count = 9'd3; start = 1'b1;
        k = 0; ntx = 0; first_k = -1; done_k = -1;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (bus.tx_start) begin
                ntx++;
                if (first_k < 0) first_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        check("to_first_tx", first_k, 3);
        check("to_done_lat", done_k - first_k, TO);
        check("to_error_set", {31'h0, error}, 1);
        check("to_tx_count", ntx, 1);
        @(negedge clk);
        check("to_error_sticky", {31'h0, error}, 1);
        uart_on = 1'b1;
        uart_delay = 3;
        run_dump(AW'($urandom()), 9'd1, 1'b0);

        // Reset during WAIT of the second byte
        fill_random();
        uart_delay = 5;
        b = AW'($urandom());
        push_dump(b, 2);
        @(negedge clk);
        base_addr = b; word_count = 9'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; ntx = 0;
        while (ntx < 2 && k < 200) begin
            @(negedge clk);
            k++;
            if (bus.tx_start) ntx++;
        end
        check("rst_reach_byte2", ntx, 2);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("rst_outputs",
              {12'h0, bus.rd_addr, bus.tx_byte, bus.tx_start, busy, done, error}, 0);
        check("rst_sb_left", exp_q.size(), 2 * NB - 2);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 arst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_dump(AW'($urandom()), 9'd2, 1'b0);

        // Randomized dumps
        for (int i = 0; i < 6; i++) begin
            fill_random();
            uart_delay = (i % 2 == 1) ? int'($urandom_range(1, 4)) : 0;
            run_dump(AW'($urandom()), (AW + 1)'($urandom_range(1, 5)), 1'b0);
        end

        // Whole memory, wrapping back to base-1
        fill_random();
        uart_delay = 1;
        run_dump(AW'($urandom()), 9'd256, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_dump_serializer.md
Name: mem_dump_serializer

Overview:
- Read-back stage downstream of the instruction memory.
- On command, walks a range of instruction-memory words and splits each DATA_WIDTH word into bytes.
- Feeds those bytes one at a time to the UART transmitter, using its tx_start/tx_done handshake.
- Used to verify a loaded program over the serial link once prog_rdy is high.

Parameters:
- ADDR_WIDTH, 8, instruction-memory address width.
- DATA_WIDTH, 32, memory word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, UART byte width.
- TIMEOUT_CYCLES, 2000000, maximum cycles to wait for tx_done after a tx_start before aborting.

Ports:
- clk  input  1  system clock.
- arst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle dump request.
- prog_rdy  input  1  program-loaded flag; start is ignored while low.
- base_addr  input  ADDR_WIDTH  first word address; sampled on accepted start.
- word_count  input  ADDR_WIDTH+1  number of words to dump; sampled on accepted start.
- rd_addr  output  ADDR_WIDTH  instruction-memory read address (registered).
- rd_data  input  DATA_WIDTH  instruction-memory read data.
- tx_byte  output  BYTE_WIDTH  byte presented to the transmitter.
- tx_start  output  1  one-cycle transmit request.
- tx_done  input  1  one-cycle pulse from the transmitter at end of stop bit.
- busy  output  1  high from accepted start until the done cycle.
- done  output  1  one-cycle pulse at completion or abort.
- error  output  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset values (async, arst_n low): all outputs 0; state IDLE; internal counters 0.
- Reset mid-operation: aborts immediately. tx_start is never left high.
- Accepted start: start=1 and prog_rdy=1 in IDLE. In that cycle, latch base_addr and word_count and clear error.
- start outside IDLE is ignored.
- States:
  - IDLE: wait for accepted start. If the latched word_count=0, go to DONE; otherwise go to ADDR.
  - ADDR: drive rd_addr = current address; go to LATCH. This state waits one cycle so both combinational and 1-cycle-synchronous memories are covered.
  - LATCH: capture rd_data into the word register; byte index = 0; go to SEND.
  - SEND: tx_byte = word[BYTE_WIDTH*idx +: BYTE_WIDTH] (little-endian, bits 7:0 first); tx_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT: tx_byte held stable.
    - On tx_done: if idx < DATA_WIDTH/BYTE_WIDTH-1, increment idx and go to SEND; otherwise go to NEXT.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 without tx_done: set error and go to DONE.
  - NEXT: address = address+1 (wraps modulo 2^ADDR_WIDTH); remaining = remaining-1. If the new remaining is 0, go to DONE; otherwise go to ADDR.
  - DONE: done=1 for one cycle; busy deasserts in the same cycle; go to IDLE.
- busy=1 in every state except IDLE and DONE.
- tx_done outside WAIT is ignored.
- tx_done and timeout expiry in the same cycle: tx_done wins and there is no error.
- Latency:
  - Accepted start (cycle 0) to first tx_start: cycle 3.
  - tx_done to the next tx_start within a word: 1 cycle.
  - Last tx_done of a word to the next word's first tx_start: 4 cycles (NEXT, ADDR, LATCH, SEND).
- word_count = 2^ADDR_WIDTH dumps the whole memory, wrapping from base_addr back to base_addr-1.
- prog_rdy dropping mid-dump does not abort the dump.

Test Plan:
- Memory word 0 = 0x12345678; start with base=0, count=1, and a tx_done pulse 5 cycles after each tx_start -> tx_byte sequence 0x78, 0x56, 0x34, 0x12; 4 tx_start pulses; first tx_start at cycle 3; done one cycle after NEXT; error=0.
- base=0xFE, count=3, memory[addr]=addr -> rd_addr visits 0xFE, 0xFF, 0x00; 12 bytes emitted; address wrap verified.
- count=0 with prog_rdy=1 -> done pulses 1 cycle after start; no tx_start; busy never asserted.
- start while prog_rdy=0, then a second start while busy -> both ignored; the in-flight dump completes unchanged.
- TIMEOUT_CYCLES=16 with tx_done never returned -> error=1 and a done pulse 16 cycles after the first tx_start; the next accepted start clears error.
- arst_n asserted during WAIT of the second byte -> all outputs 0 immediately; after release, a new start dumps correctly from byte 0.
